des_round_seq: RTL and testbench



---
 rtl/des_pkg.sv | 17 +
 rtl/des_round_seq.sv | 125 ++++++++++++
 tb/tb_des_round_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES sequencer types and constants
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } des_state_e;

  localparam int DES_ROUNDS = 16;
  localparam int DES_IDX_W  = 4;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/des_round_seq.sv
// rtl/des_round_seq.sv - iterative DES round sequencer (control only, no data path)
module des_round_seq
  import des_pkg::*;
#(
  parameter int ROUNDS = DES_ROUNDS,
  parameter int IDX_W  = DES_IDX_W,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             decrypt_in,
  input  logic             abort,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [IDX_W-1:0] dp_round_idx,
  output logic [IDX_W-1:0] dp_kidx,
  output logic             dp_last,
  output logic             dp_capture,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  des_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             decrypt_q, decrypt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_last;

  // dp_last and the ROUND->FINAL transition share this single compare
  assign is_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      decrypt_q <= MODE_ENC;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      decrypt_q <= decrypt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    decrypt_d    = decrypt_q;
    cnt_d        = cnt_q;
    in_ready     = 1'b0;
    dp_load      = 1'b0;
    dp_round_en  = 1'b0;
    dp_round_idx = '0;
    dp_kidx      = '0;
    dp_last      = 1'b0;
    dp_capture   = 1'b0;
    out_valid    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dp_load   = 1'b1;
          decrypt_d = decrypt_in;
          idx_d     = '0;
          state_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        dp_round_en  = 1'b1;
        dp_round_idx = idx_q;
        dp_kidx      = (decrypt_q == MODE_DEC) ? (LAST_IDX - idx_q) : idx_q;
        dp_last      = is_last;
        if (is_last) begin
          idx_d   = '0;
          state_d = ST_FINAL;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_FINAL: begin
        dp_capture = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (in_valid) begin
            dp_load   = 1'b1;
            decrypt_d = decrypt_in;
            idx_d     = '0;
            state_d   = ST_ROUND;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over every transition and blocks acceptance and capture
    if (abort) begin
      state_d    = ST_IDLE;
      idx_d      = '0;
      decrypt_d  = decrypt_q;
      cnt_d      = cnt_q;
      in_ready   = 1'b0;
      dp_load    = 1'b0;
      dp_capture = 1'b0;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign blk_cnt = cnt_q;

endmodule

// File: tb/tb_des_round_seq.sv
// tb/tb_des_round_seq.sv - directed self-checking bench for des_round_seq
module tb_des_round_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       decrypt_in = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, dp_load, dp_round_en, dp_last, dp_capture, out_valid, busy;
  logic [3:0] dp_round_idx, dp_kidx;
  logic [15:0] blk_cnt;

  logic       w_in_ready, w_dp_load, w_dp_round_en, w_dp_last, w_dp_capture, w_out_valid, w_busy;
  logic [3:0] w_dp_round_idx, w_dp_kidx;
  logic [1:0] w_blk_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int seen_bad;

  always #5 clk = ~clk;

  des_round_seq #(.ROUNDS(16), .IDX_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .decrypt_in(decrypt_in), .abort(abort), .dp_load(dp_load),
    .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx), .dp_kidx(dp_kidx),
    .dp_last(dp_last), .dp_capture(dp_capture), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .blk_cnt(blk_cnt)
  );

  des_round_seq #(.ROUNDS(16), .IDX_W(4), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .decrypt_in(decrypt_in), .abort(abort), .dp_load(w_dp_load),
    .dp_round_en(w_dp_round_en), .dp_round_idx(w_dp_round_idx), .dp_kidx(w_dp_kidx),
    .dp_last(w_dp_last), .dp_capture(w_dp_capture), .out_valid(w_out_valid),
    .out_ready(out_ready), .busy(w_busy), .blk_cnt(w_blk_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic accept(input logic dec);
    in_valid   = 1'b1;
    decrypt_in = dec;
    settle();
    check_eq("accept_load", dp_load, 1);
    check_eq("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_rounds(input logic dec);
    for (int r = 0; r < 16; r++) begin
      settle();
      check_eq($sformatf("round_en_%0d", r), dp_round_en, 1);
      check_eq($sformatf("round_idx_%0d", r), dp_round_idx, r);
      check_eq($sformatf("kidx_%0d", r), dp_kidx, dec ? 15 - r : r);
      check_eq($sformatf("last_%0d", r), dp_last, (r == 15));
      check_eq($sformatf("round_noload_%0d", r), dp_load, 0);
      check_eq($sformatf("round_nordy_%0d", r), in_ready, 0);
      check_eq($sformatf("round_noval_%0d", r), out_valid, 0);
      tick();
    end
    settle();
    check_eq("capture", dp_capture, 1);
    check_eq("capture_noround", dp_round_en, 0);
    check_eq("capture_noval", out_valid, 0);
    tick();
  endtask

  task automatic finish_block();
    settle();
    check_eq("done_valid", out_valid, 1);
    check_eq("done_nocap", dp_capture, 0);
    tick();
    exp_cnt++;
    settle();
    check_eq("after_valid", out_valid, 0);
    check_eq("after_busy", busy, 0);
    check_eq("blk_cnt", blk_cnt, exp_cnt);
    check_eq("wrap_cnt", w_blk_cnt, exp_cnt % 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_cnt", blk_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("idle_noload", dp_load, 0);
    check_eq("idle_kidx", dp_kidx, 0);

    // async reset at round idx 3, between edges
    accept(1'b0);
    for (int r = 0; r < 3; r++) tick();
    settle();
    check_eq("pre_rst_idx", dp_round_idx, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_round_en", dp_round_en, 0);
    check_eq("arst_idx", dp_round_idx, 0);
    check_eq("arst_ready", in_ready, 1);
    check_eq("arst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    accept(1'b0);
    run_rounds(1'b0);
    finish_block();

    // encrypt then decrypt single blocks
    tick();
    accept(1'b0);
    run_rounds(1'b0);
    finish_block();
    tick();
    accept(1'b1);
    run_rounds(1'b1);
    finish_block();

    // output backpressure with a new block waiting
    tick();
    accept(1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    run_rounds(1'b0);
    for (int c = 0; c < 5; c++) begin
      settle();
      check_eq($sformatf("bp_valid_%0d", c), out_valid, 1);
      check_eq($sformatf("bp_ready_%0d", c), in_ready, 0);
      check_eq($sformatf("bp_noload_%0d", c), dp_load, 0);
      tick();
    end
    out_ready = 1'b1;
    settle();
    check_eq("bp_release_load", dp_load, 1);
    check_eq("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    settle();
    check_eq("bp_cnt", blk_cnt, exp_cnt);
    check_eq("bp_wrap_cnt", w_blk_cnt, exp_cnt % 4);
    run_rounds(1'b0);
    finish_block();

    // abort at round idx 7
    tick();
    accept(1'b1);
    for (int r = 0; r < 7; r++) tick();
    abort = 1'b1;
    settle();
    check_eq("abort_at_idx", dp_round_idx, 7);
    tick();
    abort = 1'b0;
    settle();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", in_ready, 1);
    check_eq("abort_cnt", blk_cnt, exp_cnt);
    seen_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (dp_capture || out_valid || busy) seen_bad++;
      tick();
    end
    check_eq("abort_quiet", seen_bad, 0);
    check_eq("abort_cnt_hold", blk_cnt, exp_cnt);
    check_eq("abort_wrap_hold", w_blk_cnt, exp_cnt % 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
